// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one DW-bit datapath between four requesters.
// The owner's word is driven downstream through a combinational 4:1 mux with a
// valid/ready handshake. Each grant is limited to MAX_HOLD accepted beats.
module rr_mux4_arbiter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  input  logic [DW-1:0] data_c,
  input  logic [DW-1:0] data_d,
  input  logic          out_ready,
  output logic [3:0]    grant,
  output logic          s0,
  output logic          s1,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam int unsigned CW = 8;
  // Count value at which the next accepted beat ends the burst.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    sel;
  logic [CW-1:0] count;
  logic [1:0]    pick;
  logic          pick_vld;
  logic          owner_req;
  logic          accept;

  assign s0        = sel[0];
  assign s1        = sel[1];
  assign busy      = (state == GRANT);
  assign owner_req = req[sel];
  assign out_valid = (state == GRANT) && owner_req;
  assign accept    = out_valid && out_ready;

  // Pick the first requester scanning ptr, ptr+1, ... (mod 4); the lowest
  // offset is visited last so it wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        pick     = ptr + 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

  // Combinational 4:1 data mux driven by the registered selects.
  always_comb begin
    out_data = data_a;
    case (sel)
      2'd0: out_data = data_a;
      2'd1: out_data = data_b;
      2'd2: out_data = data_c;
      2'd3: out_data = data_d;
    endcase
  end

  // Arbitration FSM: grant on a request, release on request drop or burst limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= GRANT;
            grant <= 4'b0001 << pick;
            sel   <= pick;
            count <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || (accept && (count == HOLD_LAST))) begin
            state <= IDLE;
            grant <= 4'b0000;
            ptr   <= sel + 2'd1;
            count <= '0;
          end else if (accept) begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios plus randomized
// traffic checked against an integer-level arbitration model. Instance 0 uses
// MAX_HOLD=8, instance 1 uses MAX_HOLD=1; both share the same stimulus.
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] da = 16'h0000, db = 16'h0000, dc = 16'h0000, dd = 16'h0000;
  logic        out_ready = 1'b0;

  logic [3:0]  grant0, grant1;
  logic        s0_0, s1_0, s0_1, s1_1;
  logic        ov0, ov1, busy0, busy1;
  logic [15:0] od0, od1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.DW(16), .MAX_HOLD(8)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .out_ready(out_ready), .grant(grant0), .s0(s0_0), .s1(s1_0),
    .out_valid(ov0), .out_data(od0), .busy(busy0)
  );

  rr_mux4_arbiter #(.DW(16), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .out_ready(out_ready), .grant(grant1), .s0(s0_1), .s1(s1_1),
    .out_valid(ov1), .out_data(od1), .busy(busy1)
  );

  // Per-instance views for looped comparisons.
  logic [3:0]  g_a  [2];
  logic [1:0]  sl_a [2];
  logic        v_a  [2];
  logic        b_a  [2];
  logic [15:0] d_a  [2];
  assign g_a[0] = grant0;  assign g_a[1] = grant1;
  assign sl_a[0] = {s1_0, s0_0};  assign sl_a[1] = {s1_1, s0_1};
  assign v_a[0] = ov0;  assign v_a[1] = ov1;
  assign b_a[0] = busy0;  assign b_a[1] = busy1;
  assign d_a[0] = od0;  assign d_a[1] = od1;

  // Reference model: owner is an integer (-1 = nobody), beats counted per grant.
  int m_own [2] = '{-1, -1};
  int m_ptr [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_sel [2] = '{0, 0};
  int m_max [2] = '{8, 1};

  // Model update on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_sel[k] = 0;
      end else if (m_own[k] < 0) begin
        for (int off = 0; off < 4; off++) begin
          if (m_own[k] < 0 && req[(m_ptr[k] + off) % 4]) begin
            m_own[k] = (m_ptr[k] + off) % 4;
            m_sel[k] = m_own[k];
            m_cnt[k] = 0;
          end
        end
      end else if (!req[m_own[k]]) begin
        m_ptr[k] = (m_own[k] + 1) % 4; m_own[k] = -1; m_cnt[k] = 0;
      end else if (out_ready) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == m_max[k]) begin
          m_ptr[k] = (m_own[k] + 1) % 4; m_own[k] = -1; m_cnt[k] = 0;
        end
      end
    end
  end

  function automatic logic [3:0] e_grant(int k);
    return (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
  endfunction

  function automatic logic e_valid(int k);
    return (m_own[k] >= 0) && req[m_own[k]];
  endfunction

  function automatic logic [15:0] e_data(int k);
    case (m_sel[k])
      0:       return da;
      1:       return db;
      2:       return dc;
      default: return dd;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle after a reset edge, with rst low for that cycle.
  task automatic do_reset();
    tick(); rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(); rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (g_a[k] !== 4'b0000) begin n_fail++; $display("FAIL reset_grant%0d got %b want 0000", k, g_a[k]); end
      n_tests++;
      if (sl_a[k] !== 2'b00) begin n_fail++; $display("FAIL reset_sel%0d got %b want 00", k, sl_a[k]); end
      n_tests++;
      if (v_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid%0d got %b want 0", k, v_a[k]); end
      n_tests++;
      if (b_a[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy%0d got %b want 0", k, b_a[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_c();
    logic [3:0] eg;
    do_reset();
    da = 16'h1111; db = 16'h2222; dc = 16'h1234; dd = 16'h4444;
    req = 4'b0100; out_ready = 1'b1;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      if (cyc > 0) tick();
      @(negedge clk);
      eg = ((cyc >= 1 && cyc <= 8) || cyc == 10) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (grant0 !== eg) begin n_fail++; $display("FAIL single_c_grant cyc%0d got %b want %b", cyc, grant0, eg); end
      if (eg != 4'b0000) begin
        n_tests++;
        if ({s1_0, s0_0} !== 2'b10) begin n_fail++; $display("FAIL single_c_sel cyc%0d got %b want 10", cyc, {s1_0, s0_0}); end
        n_tests++;
        if (ov0 !== 1'b1 || od0 !== 16'h1234) begin n_fail++; $display("FAIL single_c_data cyc%0d got v=%b %h want v=1 1234", cyc, ov0, od0); end
      end else begin
        n_tests++;
        if (ov0 !== 1'b0) begin n_fail++; $display("FAIL single_c_idle_valid cyc%0d got %b want 0", cyc, ov0); end
      end
      n_tests++;
      if (grant1 !== e_grant(1)) begin n_fail++; $display("FAIL single_c_grant1 cyc%0d got %b want %b", cyc, grant1, e_grant(1)); end
    end
  endtask

  task automatic test_all_req();
    int pos;
    int gi;
    logic [3:0] eg;
    logic [15:0] ed;
    do_reset();
    da = 16'hA0A0; db = 16'hB1B1; dc = 16'hC2C2; dd = 16'hD3D3;
    req = 4'b1111; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 37; cyc++) begin
      tick();
      @(negedge clk);
      pos = (cyc - 1) % 9;
      gi  = ((cyc - 1) / 9) % 4;
      eg  = (pos < 8) ? 4'(1 << gi) : 4'b0000;
      n_tests++;
      if (grant0 !== eg) begin n_fail++; $display("FAIL all_req_grant cyc%0d got %b want %b", cyc, grant0, eg); end
      if (pos < 8) begin
        ed = (gi == 0) ? 16'hA0A0 : (gi == 1) ? 16'hB1B1 : (gi == 2) ? 16'hC2C2 : 16'hD3D3;
        n_tests++;
        if ({s1_0, s0_0} !== 2'(gi)) begin n_fail++; $display("FAIL all_req_sel cyc%0d got %0d want %0d", cyc, {s1_0, s0_0}, gi); end
        n_tests++;
        if (od0 !== ed) begin n_fail++; $display("FAIL all_req_data cyc%0d got %h want %h", cyc, od0, ed); end
      end
    end
  endtask

  task automatic test_stall();
    int pat [13] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [3:0] eg;
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      out_ready = (cyc <= 13) ? 1'(pat[cyc-1]) : 1'b1;
      @(negedge clk);
      eg = (cyc <= 13) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (grant0 !== eg) begin n_fail++; $display("FAIL stall_grant cyc%0d got %b want %b", cyc, grant0, eg); end
      n_tests++;
      if (ov0 !== (cyc <= 13)) begin n_fail++; $display("FAIL stall_valid cyc%0d got %b want %b", cyc, ov0, (cyc <= 13)); end
    end
  endtask

  task automatic test_drop_b();
    do_reset();
    req = 4'b1010; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      req = (cyc >= 4) ? 4'b1000 : 4'b1010;
      @(negedge clk);
      if (cyc <= 4) begin
        n_tests++;
        if (grant0 !== 4'b0010) begin n_fail++; $display("FAIL drop_b_grant cyc%0d got %b want 0010", cyc, grant0); end
        n_tests++;
        if (ov0 !== (cyc <= 3)) begin n_fail++; $display("FAIL drop_b_valid cyc%0d got %b want %b", cyc, ov0, (cyc <= 3)); end
      end else if (cyc == 5) begin
        n_tests++;
        if (grant0 !== 4'b0000) begin n_fail++; $display("FAIL drop_b_bubble got %b want 0000", grant0); end
      end else begin
        n_tests++;
        if (grant0 !== 4'b1000 || {s1_0, s0_0} !== 2'b11) begin n_fail++; $display("FAIL drop_b_next got %b sel %b want 1000 sel 11", grant0, {s1_0, s0_0}); end
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      req = 4'b1111;
      rst = (cyc == 4);
      @(negedge clk);
      if (cyc == 4) begin
        n_tests++;
        if (grant0 !== 4'b1000 || ov0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b v=%b want 1000 v=1", grant0, ov0); end
      end else if (cyc == 5) begin
        n_tests++;
        if (grant0 !== 4'b0000 || ov0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got %b v=%b want 0000 v=0", grant0, ov0); end
      end else if (cyc == 6) begin
        n_tests++;
        if (grant0 !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_regrant got %b want 0001", grant0); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_max_hold1();
    logic [3:0] exp_seq [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1001; out_ready = 1'b1;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc > 0) tick();
      @(negedge clk);
      n_tests++;
      if (grant1 !== exp_seq[cyc]) begin n_fail++; $display("FAIL hold1_grant cyc%0d got %b want %b", cyc, grant1, exp_seq[cyc]); end
      n_tests++;
      if (ov1 !== (exp_seq[cyc] != 4'b0000)) begin n_fail++; $display("FAIL hold1_valid cyc%0d got %b", cyc, ov1); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) tick();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      da = 16'($urandom); db = 16'($urandom); dc = 16'($urandom); dd = 16'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (g_a[k] !== e_grant(k)) begin n_fail++; $display("FAIL rand_grant%0d cyc%0d got %b want %b", k, cyc, g_a[k], e_grant(k)); end
        n_tests++;
        if (sl_a[k] !== 2'(m_sel[k])) begin n_fail++; $display("FAIL rand_sel%0d cyc%0d got %0d want %0d", k, cyc, sl_a[k], m_sel[k]); end
        n_tests++;
        if (v_a[k] !== e_valid(k)) begin n_fail++; $display("FAIL rand_valid%0d cyc%0d got %b want %b", k, cyc, v_a[k], e_valid(k)); end
        n_tests++;
        if (b_a[k] !== (m_own[k] >= 0)) begin n_fail++; $display("FAIL rand_busy%0d cyc%0d got %b want %b", k, cyc, b_a[k], (m_own[k] >= 0)); end
        if (e_valid(k)) begin
          n_tests++;
          if (d_a[k] !== e_data(k)) begin n_fail++; $display("FAIL rand_data%0d cyc%0d got %h want %h", k, cyc, d_a[k], e_data(k)); end
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_c();
    test_all_req();
    test_stall();
    test_drop_b();
    test_rst_mid();
    test_max_hold1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 16-bit datapath between four requesters (A–D).
- Each requester is a source on a 4:1 16-bit mux; the arbiter drives the mux selects, presents the selected word downstream with a valid/ready handshake, and limits each owner to a bounded burst.
- Sits between requesting units and a shared consumer (bus/write port).

Parameters:
- DW, 16, data width of each source and of out_data.
- MAX_HOLD, 8, max accepted beats per grant before forced release; legal 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit0=A, bit1=B, bit2=C, bit3=D.
- data_a  input  DW  source A data.
- data_b  input  DW  source B data.
- data_c  input  DW  source C data.
- data_d  input  DW  source D data.
- out_ready  input  1  downstream accepts the word when high with out_valid.
- grant  output  4  one-hot current owner; 0 when idle.
- s0  output  1  mux select LSB.
- s1  output  1  mux select MSB.
- out_valid  output  1  out_data is valid this cycle.
- out_data  output  DW  selected source word.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (rst high at clock edge), values on the following cycle:
  - state=IDLE, grant=0000, {s1,s0}=00, rr pointer ptr=0, beat count=0, out_valid=0, busy=0.
  - out_data follows the mux (data_a) and is don't-care while out_valid=0.
  - rst overrides all other activity, including mid-burst. The in-flight word is dropped and not counted.
- Select encoding, registered with grant:
  - owner 0 → {s1,s0}=00 → data_a; 1 → 01 → data_b; 2 → 10 → data_c; 3 → 11 → data_d.
  - out_data is a purely combinational 4:1 mux of data_a..d by {s1,s0}; no data registering.
- State machine: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the first requester with req set, scanning ptr, ptr+1, ... mod 4.
  - At the edge: grant=onehot(owner), selects=owner, count=0, state=GRANT.
  - Grant latency is one cycle after req is sampled.
- GRANT:
  - out_valid = req[owner]; busy=1.
  - Beat accepted when out_valid && out_ready; count increments by 1 on each accepted beat only.
  - Release at the clock edge when either:
    - (a) req[owner]==0 (no transfer that cycle), or
    - (b) a beat is accepted and count+1==MAX_HOLD.
  - On release: state=IDLE, grant=0000, ptr=(owner+1) mod 4 (3 wraps to 0), count=0. Selects keep their last value.
  - While stalled (out_ready=0, req[owner]=1): grant, selects and count hold; out_valid stays 1; out_data tracks the owner's source.
- Every release is followed by exactly one IDLE cycle (one-cycle bubble) before the next grant, even if requests are pending.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle. There is no preemption.
- grant is always one-hot or zero. out_valid is never high in IDLE.
- count width is 8 bits. MAX_HOLD=1 yields single-beat grants.

Test Plan:
- rst, then req=0100, data_c=16'h1234, out_ready=1 held → grant=0100, {s1,s0}=10 one cycle later; out_valid=1 with out_data=16'h1234 for 8 beats; grant=0000 for 1 cycle; grant=0100 again.
- req=1111 and out_ready=1 held → grant sequence 0001, 0010, 0100, 1000, 0001; each grant lasts 8 cycles, separated by 1 idle cycle, with matching selects 00, 01, 10, 11.
- Owner A holds req; out_ready pattern 1,1,0,0,0,0,0,1... → count does not advance during the 5 stall cycles; grant=0001 stays stable; release comes after the 8th accepted beat, 13 cycles after the grant.
- req=1010, owner B drops req after 3 accepted beats → release the next edge with no 4th beat; ptr=2; next grant=1000 (D), not B.
- rst asserted on beat 4 of an owner D burst with req=1111 → next cycle grant=0000, out_valid=0; rst deasserted → grant=0001 one cycle later (ptr reset to 0).
- MAX_HOLD=1, req=1001, out_ready=1 → grant alternates 0001, idle, 1000, idle, 0001, each grant exactly 1 beat; ptr wraps from 3 to 0.
